mem_test_sequencer: RTL

MEM_TEST_SEQUENCER -- requirements
Module: mem_test_sequencer

---
 rtl/mem_test_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_test_sequencer.sv
// Dual-port memory self-test sequencer: writes a data pattern across the address
// range two words per cycle, reads it back, and counts/locates mismatching words.
module mem_test_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int LAST_ADDR = 2**ADDR_W - 1,
  parameter int RD_LAT    = 1,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] din1,
  output logic [DATA_W-1:0] din2,
  output logic              wen1,
  output logic              wen2,
  input  logic [DATA_W-1:0] dout1,
  input  logic [DATA_W-1:0] dout2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(LAST_ADDR);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        pat_q;
  logic [1:0]        drain_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] fail_q;

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] dly_addr_q [RD_LAT];

  logic [ADDR_W-1:0] a_p1;
  logic [ADDR_W-1:0] slot_a;
  logic [ADDR_W-1:0] slot_a1;
  logic              slot_vld;
  logic              err1;
  logic              err2;
  logic [ERR_W:0]    err_sum;
  logic [ERR_W-1:0]  err_d;

  function automatic logic [DATA_W-1:0] pat_fn(input logic [1:0] sel,
                                               input logic [ADDR_W-1:0] x);
    logic [DATA_W-1:0] alt;
    for (int i = 0; i < DATA_W; i++) alt[i] = ((i % 2) == 1);
    case (sel)
      2'd0:    return DATA_W'(x);
      2'd1:    return ~DATA_W'(x);
      2'd2:    return x[0] ? ~alt : alt;
      default: return '1;
    endcase
  endfunction

  assign a_p1 = a_q + ADDR_W'(1);

  // Memory-side outputs are a pure decode of the state register and address counter.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    addr1 = '0;
    addr2 = ADDR_W'(1);
    din1  = '0;
    din2  = '0;
    wen1  = 1'b0;
    wen2  = 1'b0;
    if (state_q == S_WRITE || state_q == S_READ) begin
      addr1 = a_q;
      addr2 = a_p1;
    end
    if (state_q == S_WRITE) begin
      wen1 = 1'b1;
      wen2 = 1'b1;
      din1 = pat_fn(pat_q, a_q);
      din2 = pat_fn(pat_q, a_p1);
    end
  end

  assign busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;

  // Compare the read data against the address that produced it RD_LAT cycles ago.
  assign slot_vld = vld_q[RD_LAT-1];
  assign slot_a   = dly_addr_q[RD_LAT-1];
  assign slot_a1  = slot_a + ADDR_W'(1);
  assign err1     = slot_vld && (dout1 != pat_fn(pat_q, slot_a));
  assign err2     = slot_vld && (dout2 != pat_fn(pat_q, slot_a1));
  assign err_sum  = {1'b0, err_q} + (ERR_W+1)'(err1) + (ERR_W+1)'(err2);
  assign err_d    = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the delay line is a small register array, so it is reset like any other
      // state; stale valid bits must never survive an aborted run.
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dly_addr_q[i] <= '0;
    end else begin
      vld_q[0]      <= (state_q == S_READ);
      dly_addr_q[0] <= a_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]      <= vld_q[i-1];
        dly_addr_q[i] <= dly_addr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      pat_q   <= '0;
      drain_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      if (slot_vld) begin
        err_q <= err_d;
        // A zero count means no error has been seen yet in this run; port 1 wins ties.
        if ((err1 || err2) && (err_q == '0)) fail_q <= err1 ? slot_a : slot_a1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_q   <= pattern_sel;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            a_q     <= '0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (a_p1 == LAST_A) begin
            a_q     <= '0;
            state_q <= S_READ;
          end else begin
            a_q <= a_q + ADDR_W'(2);
          end
        end
        S_READ: begin
          if (a_p1 == LAST_A) begin
            a_q     <= '0;
            drain_q <= '0;
            state_q <= S_DRAIN;
          end else begin
            a_q <= a_q + ADDR_W'(2);
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
